// File: rtl/mem_port_arb.sv
// Arbiter for the shared instruction/data memory port: one outstanding transaction,
// load/store priority with a fetch starvation guard, and discard of flushed fetch responses.
module mem_port_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned DataW = 32;
  localparam logic        SelIf = 1'b0;
  localparam logic        SelLs = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              side;
  logic              side_req;
  logic              gnt;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= SelIf;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Next state and port outputs
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    side        = sel_q;
    side_req    = 1'b0;
    gnt         = 1'b0;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (ls_req_i && ((cnt_q < CntW'(STARVE_MAX)) || !if_req_i)) begin
          side     = SelLs;
          side_req = 1'b1;
        end else if (if_req_i) begin
          side     = SelIf;
          side_req = 1'b1;
        end
        if (side_req) begin
          sel_d   = side;
          state_d = mem_gnt_i ? WAIT : REQ;
        end
      end
      REQ: begin
        // Owner is locked; a fetch withdrawn on flush releases the port without a grant.
        side_req = (sel_q == SelLs) ? ls_req_i : if_req_i;
        if (!side_req)      state_d = IDLE;
        else if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (sel_q == SelLs) ls_rvalid_o = 1'b1;
          else                if_rvalid_o = !drop_q && !if_flush_i;
        end else if (if_flush_i && (sel_q == SelIf)) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt      = side_req && mem_gnt_i;
    if_gnt_o = gnt && (side == SelIf);
    ls_gnt_o = gnt && (side == SelLs);

    if (ls_gnt_o) begin
      if (!if_req_i)                       cnt_d = '0;
      else if (cnt_q >= CntW'(STARVE_MAX)) cnt_d = CntW'(STARVE_MAX);
      else                                 cnt_d = cnt_q + CntW'(1);
    end
    if (if_gnt_o) begin
      cnt_d = '0;
      if (if_flush_i) drop_d = 1'b1;
    end

    mem_req_o = side_req;

    // Force every handshake low while reset is asserted
    if (!rst_ni) begin
      mem_req_o   = 1'b0;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
    end
  end

  // Payload mux: fetch is always a full-word read
  assign mem_we_o    = (side == SelLs) ? ls_we_i    : 1'b0;
  assign mem_be_o    = (side == SelLs) ? ls_be_i    : 4'hF;
  assign mem_addr_o  = (side == SelLs) ? ls_addr_i  : if_addr_i;
  assign mem_wdata_o = (side == SelLs) ? ls_wdata_i : DataW'(0);

  assign if_rdata_o = mem_rdata_i;
  assign ls_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model of the port.
module tb_mem_port_arb;

  localparam int unsigned STARVE = 4;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_be;
  logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 = none, 1 = fetch, 2 = load/store
  int m_lock, m_out, m_streak;
  bit m_discard;
  int e_side;
  bit e_mem_req, e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv;

  always #5 clk_i = ~clk_i;

  mem_port_arb #(.STARVE_MAX(STARVE)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_flush_i  (if_flush),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .ls_req_i    (ls_req),
    .ls_we_i     (ls_we),
    .ls_be_i     (ls_be),
    .ls_addr_i   (ls_addr),
    .ls_wdata_i  (ls_wdata),
    .ls_gnt_o    (ls_gnt_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_lock = 0; m_out = 0; m_streak = 0; m_discard = 1'b0;
  endtask

  // Expected port behaviour for the current inputs
  task automatic model_eval();
    e_side = 0; e_mem_req = 0; e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0;
    if (m_out != 0) begin
      if (mem_rvalid) begin
        if (m_out == 2) e_ls_rv = 1'b1;
        else            e_if_rv = !(m_discard || if_flush);
      end
    end else begin
      if (m_lock != 0)                                      e_side = m_lock;
      else if (ls_req && (m_streak < int'(STARVE) || !if_req)) e_side = 2;
      else if (if_req)                                      e_side = 1;
      e_mem_req = (e_side == 1) ? if_req : (e_side == 2) ? ls_req : 1'b0;
      if (e_mem_req && mem_gnt) begin
        if (e_side == 1) e_if_gnt = 1'b1;
        else             e_ls_gnt = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    if (m_out != 0) begin
      if (mem_rvalid) begin
        m_out = 0;
        m_discard = 1'b0;
      end else if (if_flush && m_out == 1) begin
        m_discard = 1'b1;
      end
    end else if (e_if_gnt || e_ls_gnt) begin
      m_out  = e_side;
      m_lock = 0;
      if (e_ls_gnt) begin
        m_streak = if_req ? ((m_streak + 1 > int'(STARVE)) ? int'(STARVE) : m_streak + 1) : 0;
      end else begin
        m_streak = 0;
        if (if_flush) m_discard = 1'b1;
      end
    end else begin
      m_lock = e_mem_req ? e_side : 0;
    end
  endtask

  task automatic eval_check();
    #1;
    model_eval();
    check("if_gnt",    32'(if_gnt_o),    32'(e_if_gnt));
    check("ls_gnt",    32'(ls_gnt_o),    32'(e_ls_gnt));
    check("mem_req",   32'(mem_req_o),   32'(e_mem_req));
    check("if_rvalid", 32'(if_rvalid_o), 32'(e_if_rv));
    check("ls_rvalid", 32'(ls_rvalid_o), 32'(e_ls_rv));
    if (e_mem_req) begin
      check("mem_we",    32'(mem_we_o), (e_side == 2) ? 32'(ls_we) : 32'd0);
      check("mem_be",    32'(mem_be_o), (e_side == 2) ? 32'(ls_be) : 32'hF);
      check("mem_addr",  mem_addr_o,    (e_side == 2) ? ls_addr    : if_addr);
      check("mem_wdata", mem_wdata_o,   (e_side == 2) ? ls_wdata   : 32'd0);
    end
    if (e_if_rv) check("if_rdata", if_rdata_o, mem_rdata);
    if (e_ls_rv) check("ls_rdata", ls_rdata_o, mem_rdata);
    model_update();
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_flush = 0; ls_req = 0; ls_we = 0; ls_be = '0;
    ls_addr = '0; ls_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, "_mem_req"},   32'(mem_req_o),   32'd0);
    check({tag, "_if_gnt"},    32'(if_gnt_o),    32'd0);
    check({tag, "_ls_gnt"},    32'(ls_gnt_o),    32'd0);
    check({tag, "_if_rvalid"}, 32'(if_rvalid_o), 32'd0);
    check({tag, "_ls_rvalid"}, 32'(ls_rvalid_o), 32'd0);
  endtask

  // Both sides always requesting, memory grants and responds with no wait states
  task automatic grant_run(input int n, output int order[$]);
    int cyc = 0;
    order = {};
    if_req = 1; ls_req = 1; mem_gnt = 1;
    while (order.size() < n && cyc < 60) begin
      mem_rvalid = (m_out != 0);
      mem_rdata  = $urandom;
      eval_check();
      if (if_gnt_o) order.push_back(1);
      else if (ls_gnt_o) order.push_back(2);
      advance();
      cyc++;
    end
    check("grant_run_timeout", 32'(order.size()), 32'(n));
  endtask

  int order[$];
  int exp_order[6] = '{2, 2, 2, 2, 1, 2};
  bit if_hold, ls_hold;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    if_req = 1; mem_gnt = 1; ls_req = 1;
    #2;
    check_outputs_low("reset");
    @(posedge clk_i); #1;
    idle_inputs();
    rst_n = 1;
    #1;
    // eval_check adds its own #1; realign to posedge+1 first
    advance();

    // Lone fetch, granted at once, response two cycles later
    if_req = 1; if_addr = 32'h10; mem_gnt = 1;
    eval_check();
    check("tp1_if_gnt", 32'(if_gnt_o), 32'd1);
    check("tp1_mem_be", 32'(mem_be_o), 32'hF);
    check("tp1_mem_we", 32'(mem_we_o), 32'd0);
    advance();
    if_req = 0; mem_gnt = 0;
    eval_check(); advance();
    mem_rvalid = 1; mem_rdata = 32'h13;
    eval_check();
    check("tp1_if_rvalid", 32'(if_rvalid_o), 32'd1);
    check("tp1_if_rdata", if_rdata_o, 32'h13);
    advance();
    mem_rvalid = 0;
    eval_check();
    check("tp1_bubble", 32'(mem_req_o), 32'd0);
    advance();

    // Simultaneous requests: LS write wins, fetch follows the LS response
    if_req = 1; if_addr = 32'h20;
    ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
    mem_gnt = 1;
    eval_check();
    check("tp2_ls_gnt", 32'(ls_gnt_o), 32'd1);
    check("tp2_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    advance();
    ls_req = 0; mem_gnt = 0;
    eval_check(); advance();
    mem_rvalid = 1; mem_rdata = 32'h0;
    eval_check();
    check("tp2_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    advance();
    mem_rvalid = 0; mem_gnt = 1;
    eval_check();
    check("tp2_if_gnt_after", 32'(if_gnt_o), 32'd1);
    advance();
    if_req = 0; mem_gnt = 0;
    eval_check(); advance();
    mem_rvalid = 1; mem_rdata = 32'h77;
    eval_check(); advance();
    idle_inputs();

    // Flush one cycle before the fetch response, then a clean fetch
    if_req = 1; if_addr = 32'h40; mem_gnt = 1;
    eval_check(); advance();
    if_req = 0; mem_gnt = 0; if_flush = 1;
    eval_check(); advance();
    if_flush = 0; mem_rvalid = 1; mem_rdata = 32'hBAD;
    eval_check();
    check("tp4_dropped", 32'(if_rvalid_o), 32'd0);
    advance();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h200; mem_gnt = 1;
    eval_check();
    check("tp4_next_gnt", 32'(if_gnt_o), 32'd1);
    advance();
    if_req = 0; mem_gnt = 0;
    eval_check(); advance();
    mem_rvalid = 1; mem_rdata = 32'h55;
    eval_check();
    check("tp4_next_rdata", 32'(if_rvalid_o) << 31 | if_rdata_o, 32'h8000_0055);
    advance();
    idle_inputs();

    // Fetch stalls in REQ, LS arrives, fetch withdrawn on flush
    if_req = 1; if_addr = 32'h300;
    eval_check(); advance();
    ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h400;
    eval_check();
    check("tp5_locked", 32'(ls_gnt_o), 32'd0);
    check("tp5_lock_addr", mem_addr_o, 32'h300);
    advance();
    if_req = 0; if_flush = 1;
    eval_check();
    check("tp5_no_if_gnt", 32'(if_gnt_o), 32'd0);
    advance();
    if_flush = 0; mem_gnt = 1;
    eval_check();
    check("tp5_ls_gnt", 32'(ls_gnt_o), 32'd1);
    advance();
    ls_req = 0; mem_gnt = 0;
    eval_check(); advance();
    mem_rvalid = 1; mem_rdata = 32'h1234;
    eval_check(); advance();
    idle_inputs();

    // Two LS grants build the streak, reset mid-response clears it
    grant_run(2, order);
    for (int i = 0; i < order.size(); i++) check("pre_reset_order", 32'(order[i]), 32'd2);
    rst_n = 0;
    mem_rvalid = 1;
    #1;
    check_outputs_low("mid_reset");
    model_reset();
    advance();
    rst_n = 1;
    mem_rvalid = 0;
    grant_run(6, order);
    for (int i = 0; i < order.size() && i < 6; i++) check("starve_order", 32'(order[i]), 32'(exp_order[i]));
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = (m_out != 0);
      eval_check(); advance();
    end
    mem_rvalid = 0;

    // Randomized traffic obeying the request/response protocol
    if_hold = (m_lock == 1);
    ls_hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ls_hold && $urandom_range(0, 3) == 0) begin
        ls_hold = 1; ls_we = 1'($urandom); ls_be = 4'($urandom);
        ls_addr = $urandom & 32'hFFFF_FFFC; ls_wdata = $urandom;
      end
      if (!if_hold && $urandom_range(0, 2) == 0) begin
        if_hold = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_flush = ($urandom_range(0, 7) == 0);
      if (if_hold && if_flush && $urandom_range(0, 1) == 1) if_hold = 0;
      if_req = if_hold;
      ls_req = ls_hold;
      mem_gnt = 1'($urandom);
      mem_rvalid = (m_out != 0) && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      eval_check();
      if (e_if_gnt) if_hold = 0;
      if (e_ls_gnt) ls_hold = 0;
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
